spi_slave: RTL

SPI slave receiver/transmitter for the peripheral FPGA side of the link. Consumes the 16-bit, LSB-first, mode-compatible frames driven by the team's SPI master, which shifts MOSI on SCLK rise and expects the slave to sample on SCLK fall. It oversamples `sclk`/`mosi`/`cs` on the local system clock and delivers each received word to the local logic as a one-cycle strobe. It returns a locally supplied 16-bit word on `miso` during the same frame.

---
 rtl/spi_slave_pkg.sv | 16 +
 rtl/spi_slave_sync_ff.sv | 27 ++
 rtl/spi_slave.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
//   Shared link defaults for the SPI master/slave pair (frame width,
//   chip-select polarity, synchronizer depth) and the slave FSM encoding.
package spi_slave_pkg;

  localparam int   SPI_WIDTH       = 16;
  localparam logic SPI_CS_ACTIVE   = 1'b0;
  localparam int   SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync_ff.sv
// sync_ff
//   Multi-stage flip-flop synchronizer for one asynchronous input.
//   Ports:
//     clk   - system clock
//     reset - asynchronous active-low reset (chain loads RESET_VAL)
//     d     - asynchronous input
//     q     - synchronized output, STAGES clk cycles behind d
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= {STAGES{RESET_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave
//   Oversampling SPI slave: LSB-first frames, samples MOSI on SCLK fall,
//   advances MISO on SCLK fall, one-cycle rx_valid / frame_err strobes.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | cs inactive, miso low, waiting for cs to go active
//   SHIFT | frame open, fewer than WIDTH SCLK falls seen
//   FULL  | WIDTH falls seen; any further fall marks overflow
//
//   Ports:
//     clk       - system clock (>= 8x SCLK)
//     reset     - asynchronous active-low reset
//     sclk      - SPI clock from master (async)
//     mosi      - master-out data (async)
//     cs        - chip select (async), active level CS_ACTIVE
//     miso      - slave-out data
//     tx_data   - word returned to the master, captured at frame start
//     rx_data   - last good received word
//     rx_valid  - one-cycle strobe when rx_data updates
//     frame_err - one-cycle strobe for a frame with bit count != WIDTH
//     busy      - frame in progress
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int   WIDTH       = SPI_WIDTH,
  parameter logic CS_ACTIVE   = SPI_CS_ACTIVE,
  parameter int   SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             cs,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic sclk_s, mosi_s, cs_s;
  logic sclk_q;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
  );
  // cs powers up inactive so reset release never looks like a frame start
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(~CS_ACTIVE)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs), .q(cs_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sclk_q <= 1'b0;
    else        sclk_q <= sclk_s;
  end

  logic cs_on;
  logic sclk_fall;
  assign cs_on     = (cs_s == CS_ACTIVE);
  assign sclk_fall = sclk_q & ~sclk_s;

  spi_state_e       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovf;
  logic [WIDTH-1:0] rx_shift, rx_shift_nxt, tx_shift;
  logic             last_fall, frame_close, frame_good;

  assign rx_shift_nxt = {mosi_s, rx_shift[WIDTH-1:1]};
  assign last_fall    = (state == SHIFT) && sclk_fall && (bit_cnt == CNT_W'(WIDTH - 1));
  assign frame_close  = (state != IDLE) && !cs_on;
  // A fall coinciding with cs release counts first: it can complete a frame
  // in SHIFT, or overflow one already in FULL.
  assign frame_good   = last_fall || ((state == FULL) && !ovf && !sclk_fall);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_on) state_nxt = SHIFT;
      SHIFT: begin
        if (!cs_on)         state_nxt = IDLE;
        else if (last_fall) state_nxt = FULL;
      end
      FULL:    if (!cs_on) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = (state != IDLE);
    miso = 1'b0;
    if (state == SHIFT) miso = tx_shift[0];
  end

  // datapath and strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      ovf       <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_on) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            ovf      <= 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            rx_shift <= rx_shift_nxt;
            tx_shift <= tx_shift >> 1;
            if (bit_cnt != CNT_W'(WIDTH)) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        FULL: begin
          if (sclk_fall) ovf <= 1'b1;
        end
        default: ;
      endcase
      if (frame_close) begin
        if (frame_good) begin
          rx_data  <= last_fall ? rx_shift_nxt : rx_shift;
          rx_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
